// File: rtl/scan_stopwatch.sv
// BCD stopwatch with lap freeze and a multiplexed 7-segment scan driver.
// Counting, lap capture and display scanning run from one clock.
module scan_stopwatch #(
  parameter int          NDIG     = 4,
  parameter int          TICK_DIV = 10000000,
  parameter int          SCAN_DIV = 1000,
  parameter int          WRAP     = 1,
  parameter logic [7:0]  DP_MASK  = 8'h04
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            go,
  input  logic            up,
  input  logic            clr,
  input  logic            lap,
  output logic [4*NDIG-1:0] count,
  output logic            ovf,
  output logic            frozen,
  output logic [7:0]      seg,
  output logic [7:0]      an
);

  localparam int W  = 4*NDIG;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0]  ALL9  = {NDIG{4'h9}};
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV-1);
  localparam logic [SW-1:0] SLAST = SW'(SCAN_DIV-1);
  localparam logic [2:0]    ILAST = 3'(NDIG-1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [W-1:0]  cnt;
  logic [W-1:0]  snap;
  logic [W-1:0]  inc;
  logic [W-1:0]  dec;
  logic          cy;
  logic          bw;
  logic          lap_q;
  logic          rise;
  logic [SW-1:0] sc;
  logic [2:0]    idx;
  logic [31:0]   disp8;
  logic [3:0]    dig;
  logic [6:0]    hex;

  assign tick  = go && (presc == PLAST);
  assign rise  = lap && !lap_q;
  assign count = cnt;

  // Ripple carry/borrow digit by digit so each digit stays 0..9.
  always_comb begin
    inc = cnt;
    dec = cnt;
    cy  = 1'b1;
    bw  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (cy) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      presc <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (go)
        presc <= (presc == PLAST) ? '0 : presc + 1'b1;
      if (tick) begin
        if (up) begin
          if (cnt == ALL9 && WRAP == 0) ovf <= 1'b1;
          else cnt <= inc;
        end else begin
          if (cnt == '0 && WRAP == 0) ovf <= 1'b1;
          else cnt <= dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lap_q  <= 1'b0;
      frozen <= 1'b0;
      snap   <= '0;
    end else begin
      lap_q <= lap;
      if (rise) begin
        frozen <= !frozen;
        if (!frozen) snap <= cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SLAST) begin
      sc  <= '0;
      idx <= (idx == ILAST) ? 3'd0 : idx + 3'd1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  // Pad to eight digits so the slot select never runs off the end.
  always_comb begin
    disp8 = 32'(frozen ? snap : cnt);
    dig   = disp8[{idx, 2'b00} +: 4];
    case (dig)
      4'd0:    hex = 7'h40;
      4'd1:    hex = 7'h79;
      4'd2:    hex = 7'h24;
      4'd3:    hex = 7'h30;
      4'd4:    hex = 7'h19;
      4'd5:    hex = 7'h12;
      4'd6:    hex = 7'h02;
      4'd7:    hex = 7'h78;
      4'd8:    hex = 7'h00;
      4'd9:    hex = 7'h10;
      default: hex = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      seg <= 8'hFF;
      an  <= 8'hFF;
    end else begin
      seg <= {~DP_MASK[idx], hex};
      an  <= ~(8'h01 << idx);
    end
  end

endmodule

// File: tb/tb_scan_stopwatch.sv
// Bench for scan_stopwatch: WRAP=1 and WRAP=0 instances share stimulus
// and are checked each cycle against an integer-arithmetic model.
module tb_scan_stopwatch;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic go = 1'b0;
  logic up = 1'b1;
  logic clr = 1'b0;
  logic lap = 1'b0;
  logic [15:0] count1, count0;
  logic ovf1, ovf0, frz1, frz0;
  logic [7:0] seg1, seg0, an1, an0;

  always #5 clk = ~clk;

  scan_stopwatch #(.NDIG(4), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(1),
                   .DP_MASK(8'h04)) dut1 (
    .clk(clk), .rstn(rstn), .go(go), .up(up), .clr(clr), .lap(lap),
    .count(count1), .ovf(ovf1), .frozen(frz1), .seg(seg1), .an(an1));

  scan_stopwatch #(.NDIG(4), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(0),
                   .DP_MASK(8'h04)) dut0 (
    .clk(clk), .rstn(rstn), .go(go), .up(up), .clr(clr), .lap(lap),
    .count(count0), .ovf(ovf0), .frozen(frz0), .seg(seg0), .an(an0));

  localparam logic [6:0] HEX [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [7:0] DPM = 8'h04;
  localparam int POW [4] = '{1, 10, 100, 1000};

  int vectors = 0;
  int misses = 0;

  int m_presc, m_sc, m_idx;
  bit m_frz, m_lapq;
  int m_cnt [2];
  int m_snap [2];
  bit m_ovf [2];
  logic [7:0] m_seg [2];
  logic [7:0] m_an;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    bit tk;
    if (!rstn) begin
      m_presc = 0; m_sc = 0; m_idx = 0; m_frz = 0; m_lapq = 0;
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_snap[w] = 0; m_ovf[w] = 0; m_seg[w] = 8'hFF;
      end
      m_an = 8'hFF;
    end else begin
      for (int w = 0; w < 2; w++) begin
        d = m_frz ? m_snap[w] : m_cnt[w];
        m_seg[w] = {~DPM[m_idx], HEX[d / POW[m_idx] % 10]};
      end
      m_an = ~(8'h01 << m_idx);
      tk = go && (m_presc == 3);
      if (lap && !m_lapq) begin
        if (!m_frz) begin
          m_snap[0] = m_cnt[0];
          m_snap[1] = m_cnt[1];
        end
        m_frz = !m_frz;
      end
      m_lapq = lap;
      if (clr) begin
        m_presc = 0;
        for (int w = 0; w < 2; w++) begin
          m_cnt[w] = 0; m_ovf[w] = 0;
        end
      end else begin
        if (go) m_presc = (m_presc + 1) % 4;
        if (tk) begin
          for (int w = 0; w < 2; w++) begin
            if (up) begin
              if (m_cnt[w] == 9999) begin
                if (w == 1) m_cnt[w] = 0; else m_ovf[w] = 1;
              end else m_cnt[w] = m_cnt[w] + 1;
            end else begin
              if (m_cnt[w] == 0) begin
                if (w == 1) m_cnt[w] = 9999; else m_ovf[w] = 1;
              end else m_cnt[w] = m_cnt[w] - 1;
            end
          end
        end
      end
      m_sc = m_sc + 1;
      if (m_sc == 2) begin
        m_sc = 0;
        m_idx = (m_idx + 1) % 4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("count1", count1, to_bcd(m_cnt[1]));
    check("count0", count0, to_bcd(m_cnt[0]));
    check("ovf1", ovf1, m_ovf[1]);
    check("ovf0", ovf0, m_ovf[0]);
    check("frozen1", frz1, m_frz);
    check("frozen0", frz0, m_frz);
    check("seg1", seg1, m_seg[1]);
    check("seg0", seg0, m_seg[0]);
    check("an1", an1, m_an);
    check("an0", an0, m_an);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0; go = 1'b0; up = 1'b1; clr = 1'b0; lap = 1'b0;
    steps(2);
    rstn = 1'b1;
  endtask

  task automatic wait_an_fe(input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (an1 == 8'hFE) hit = 1;
    end
    check(name, hit, 1);
  endtask

  logic [7:0] an_seen [8];
  logic [7:0] an_exp [8];

  initial begin
    an_exp = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7};

    do_reset();
    check("rst_seg", seg1, 8'hFF);
    check("rst_an", an1, 8'hFF);
    check("rst_count", count1, 16'h0000);

    go = 1'b1; up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i < 8) an_seen[i] = an1;
    end
    for (int i = 0; i < 8; i++) check("an_seq", an_seen[i], an_exp[i]);
    check("cnt40", count1, 16'h0010);
    check("ovf40", ovf1, 1'b0);

    do_reset();
    go = 1'b1; up = 1'b0;
    steps(4);
    check("down_wrap", count1, 16'h9999);
    check("down_sat", count0, 16'h0000);
    check("down_ovf", ovf0, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    check("down_clr_ovf", ovf0, 1'b0);

    do_reset();
    go = 1'b1; up = 1'b1;
    steps(9999 * 4);
    check("pre9999_w1", count1, 16'h9999);
    check("pre9999_w0", count0, 16'h9999);
    check("pre9999_ovf", ovf0, 1'b0);
    steps(4);
    check("up_wrap", count1, 16'h0000);
    check("up_sat", count0, 16'h9999);
    check("up_ovf", ovf0, 1'b1);
    check("up_ovf_w1", ovf1, 1'b0);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_cnt", count0, 16'h0000);
    check("clr_ovf", ovf0, 1'b0);

    do_reset();
    go = 1'b1; up = 1'b1;
    steps(12);
    check("lap_at3", count1, 16'h0003);
    lap = 1'b1; step(); lap = 1'b0;
    steps(11);
    go = 1'b0;
    check("lap_frz", frz1, 1'b1);
    check("lap_cnt6", count1, 16'h0006);
    wait_an_fe("lap_scan1");
    check("lap_disp3", seg1[6:0], 7'h30);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_unfrz", frz1, 1'b0);
    wait_an_fe("lap_scan2");
    check("lap_disp6", seg1[6:0], 7'h02);

    do_reset();
    go = 1'b1; up = 1'b1;
    steps(7);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_tick", count1, 16'h0000);
    steps(4);
    go = 1'b0;
    steps(10);
    check("go0_hold", count1, 16'h0001);

    do_reset();
    go = 1'b1;
    for (int i = 0; i < 20 && m_idx != 2; i++) step();
    check("mid_idx2", m_idx, 2);
    rstn = 1'b0; step();
    check("mid_rst_seg", seg1, 8'hFF);
    check("mid_rst_an", an1, 8'hFF);
    rstn = 1'b1; step();
    check("rel_an", an1, 8'hFE);
    check("rel_seg", seg1, 8'hC0);

    for (int i = 0; i < 4000; i++) begin
      rstn = ($urandom_range(0, 499) != 0);
      go   = ($urandom_range(0, 7) != 0);
      up   = (i % 800 < 400) ? ($urandom_range(0, 9) != 0)
                             : ($urandom_range(0, 9) == 0);
      clr  = ($urandom_range(0, 99) == 0);
      lap  = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/scan_stopwatch.md
SCAN_STOPWATCH -- requirements
Module: scan_stopwatch

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits counted and displayed; legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 10000000: clk cycles per count tick.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clk cycles per display digit slot.
REQ-004 SHALL have parameter WRAP, default 1: 1 = wrap at count limits, 0 = saturate and flag.
REQ-005 SHALL have parameter DP_MASK, default 8'h04: bit i set lights the decimal point on digit i.
REQ-006 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port go, input, 1: count enable (level).
REQ-009 SHALL have port up, input, 1: 1 = count up, 0 = count down (level, sampled at tick).
REQ-010 SHALL have port clr, input, 1: synchronous clear of count, prescaler and ovf.
REQ-011 SHALL have port lap, input, 1: lap/freeze request (edge-detected).
REQ-012 SHALL have port count, output, 4*NDIG: live BCD count; digit 0 is least significant.
REQ-013 SHALL have port ovf, output, 1: sticky limit flag (WRAP=0 only).
REQ-014 SHALL have port frozen, output, 1: display is showing a lap snapshot.
REQ-015 SHALL have port seg, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-016 SHALL have port an, output, 8: active-low digit enables, one-hot-low.

Function
REQ-017 SHALL run a prescaler 0..TICK_DIV-1 that advances only while go=1, holds its value while go=0, and asserts an internal tick in the cycle it equals TICK_DIV-1, then returns to 0.
REQ-018 SHALL update count one cycle after the tick cycle: +1 (up=1) or -1 (up=0) in BCD, with carry/borrow rippling across all NDIG digits; every digit always 0..9.
REQ-019 SHALL, with WRAP=1, wrap all-9s+1 to all-0s and all-0s-1 to all-9s; ovf stays 0.
REQ-020 SHALL, with WRAP=0, hold count at all-9s (up) or all-0s (down) when the tick would cross the limit, and set ovf; ovf clears only on clr or reset.
REQ-021 SHALL give clr priority over tick in the same cycle: count, prescaler and ovf become 0 next cycle; frozen is unaffected.
REQ-022 SHALL detect the lap rising edge (registered previous value); each edge toggles frozen; on 0->1 the snapshot register loads the current count in the same cycle.
REQ-023 SHALL display the snapshot while frozen=1 and live count while frozen=0; counting continues while frozen.
REQ-024 SHALL run a scan counter 0..SCAN_DIV-1 and a digit index 0..NDIG-1 that advances by one when the scan counter wraps, returning from NDIG-1 to 0.
REQ-025 SHALL register an = ~(8'b1 << index); an bits NDIG..7 are always 1.
REQ-026 SHALL register seg[6:0] from the displayed digit using the hex table 0..9 = 40,79,24,30,19,12,02,78,00,10; digit values above 9 drive 7F.
REQ-027 SHALL drive seg[7] = ~DP_MASK[index].
REQ-028 SHALL reflect index, count and frozen changes on seg/an one cycle after they occur.
REQ-029 SHALL ignore up changes between ticks; only the value sampled in the tick cycle matters.

Reset
REQ-030 SHALL, while rstn=0 at a clock edge, clear prescaler, count, snapshot, ovf, frozen, lap edge register, scan counter and index to 0, and drive seg=8'hFF and an=8'hFF.
REQ-031 SHALL, on the first clock with rstn=1, drive an=~8'h01 and the segments for digit 0.
REQ-032 SHALL, when reset is asserted mid-count or mid-scan, discard all state in that cycle; no partial tick survives.

Verification (NDIG=4, TICK_DIV=4, SCAN_DIV=2)
REQ-033 SHALL check: reset, go=1, up=1 for 40 cycles -> count=0x0010, ovf=0, an cycles FE,FD,FB,F7 every 2 cycles.
REQ-034 SHALL check: preload 0x9999 via counting, WRAP=1, one more tick -> 0x0000; WRAP=0 -> holds 0x9999 with ovf=1, then clr -> 0x0000, ovf=0.
REQ-035 SHALL check: count=0x0000, up=0, one tick -> 0x9999 (WRAP=1).
REQ-036 SHALL check: lap pulse at count 0x0003, wait 3 ticks -> frozen=1, display shows 0003, count=0x0006; second lap pulse -> frozen=0, display shows 0006.
REQ-037 SHALL check: clr asserted in the tick cycle -> count 0x0000 next cycle (not 0x0001); go=0 for 10 cycles -> count unchanged.
REQ-038 SHALL check: rstn=0 mid-scan at index 2 -> next cycle seg=FF, an=FF; after release -> an=FE, seg=C0 (digit 0, dp off).
